// File: rtl/fb_mem_arbiter_pkg.sv
// Shared types for the frame-buffer memory arbiter: arbitration states and
// read-return owner tags.
package fb_arb_pkg;

  typedef enum logic [1:0] {IDLE, DISP, HOST} arb_state_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} rd_tag_t;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Bundle of display, host and memory-port signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface fb_mem_arbiter_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 24
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_urgent;
  logic          disp_ack;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, disp_urgent,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output disp_ack, disp_rvalid, disp_rdata,
    output host_ack, host_rvalid, host_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, disp_urgent,
    output host_req, host_we, host_addr, host_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  disp_ack, disp_rvalid, disp_rdata,
    input  host_ack, host_rvalid, host_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_mem_arbiter_rd_tag_pipe.sv
// Owner-tag delay line matching the fixed memory read latency; the tail tag
// steers each returning mem_rvalid to the display or host side.
module rd_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  input  logic    mem_rvalid,
  output logic    disp_rvalid,
  output logic    host_rvalid
);

  rd_tag_t pipe [RD_LAT];
  rd_tag_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail        = pipe[RD_LAT-1];
  assign disp_rvalid = mem_rvalid && (tail == TAG_DISP);
  assign host_rvalid = mem_rvalid && (tail == TAG_HOST);

  // Returned data with no outstanding read owner means the memory broke its latency contract.
  orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && tail == TAG_NONE));

endmodule

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory port arbiter: fixed-length display read bursts versus
// single host beats, with a starvation guard that yields to display urgency.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned AW       = 19,
  parameter int unsigned DW       = 24,
  parameter int unsigned BURST    = 16,
  parameter int unsigned RD_LAT   = 3,
  parameter int unsigned MAX_DISP = 4
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst_n,
  fb_mem_arbiter_if.slave bus
);

  localparam int unsigned BW = $clog2(BURST);
  localparam int unsigned SW = $clog2(MAX_DISP + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DISP);

  arb_state_t    state;
  logic [BW-1:0] beat;
  logic [SW-1:0] starve;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          accept;
  logic          grant_disp;
  rd_tag_t       tag_in;
  logic          disp_rvalid_w;
  logic          host_rvalid_w;

  assign accept     = mem_req_q && bus.mem_ready;
  assign grant_disp = bus.disp_req &&
                      (bus.disp_urgent || !bus.host_req || (starve < STARVE_MAX));

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      starve      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_disp) begin
            state       <= DISP;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.disp_addr;
            mem_wdata_q <= '0;
          end else if (bus.host_req) begin
            state       <= HOST;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.host_we;
            mem_addr_q  <= bus.host_addr;
            mem_wdata_q <= bus.host_wdata;
          end
        end
        DISP: begin
          if (accept) begin
            if (beat == LAST_BEAT) begin
              state      <= IDLE;
              beat       <= '0;
              mem_req_q  <= 1'b0;
              mem_addr_q <= '0;
              if (bus.host_req && (starve != STARVE_MAX)) starve <= starve + 1'b1;
            end else begin
              beat       <= beat + 1'b1;
              mem_addr_q <= bus.disp_addr + AW'(beat) + AW'(1);
            end
          end
        end
        HOST: begin
          if (accept) begin
            state       <= IDLE;
            starve      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acks are combinational so they coincide with the accepting cycle itself.
  assign bus.disp_ack  = (state == DISP) && accept && (beat == LAST_BEAT);
  assign bus.host_ack  = (state == HOST) && accept;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_comb begin
    tag_in = TAG_NONE;
    if (accept && !mem_we_q) tag_in = (state == DISP) ? TAG_DISP : TAG_HOST;
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk         (pixel_clk),
    .rst_n       (pixel_rst_n),
    .tag_in      (tag_in),
    .mem_rvalid  (bus.mem_rvalid),
    .disp_rvalid (disp_rvalid_w),
    .host_rvalid (host_rvalid_w)
  );

  assign bus.disp_rvalid = disp_rvalid_w;
  assign bus.host_rvalid = host_rvalid_w;
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: directed scenarios push expected memory
// commands and read returns; a negedge monitor pops and compares them.
module tb_fb_mem_arbiter;

  localparam int unsigned AW = 19, DW = 24, BURST = 16, RD_LAT = 3, MAX_DISP = 4;

  logic clk = 1'b0;
  logic rst_n;

  fb_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fb_mem_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .RD_LAT(RD_LAT), .MAX_DISP(MAX_DISP)) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .bus         (bus.slave)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   ack;    // 0 none, 1 disp_ack, 2 host_ack
    int unsigned   owner;  // 1 display, 2 host
  } cmd_t;

  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_drd[$];
  logic [DW-1:0] exp_hrd[$];
  int            acc_dcyc[$];
  int            acc_hcyc[$];
  int            n_cmp = 0, n_err = 0, cyc = 0, n_accept = 0;
  bit            toggle = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return {5'b10101, a};
  endfunction

  // Memory model: fixed-latency read returns, in-flight reads dropped on reset.
  logic [RD_LAT-1:0] rv = '0;
  logic [AW-1:0]     ra [RD_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv <= '0;
    else begin
      rv[0] <= bus.mem_req & bus.mem_ready & ~bus.mem_we;
      ra[0] <= bus.mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        rv[i] <= rv[i-1];
        ra[i] <= ra[i-1];
      end
    end
  end
  assign bus.mem_rvalid = rv[RD_LAT-1];
  assign bus.mem_rdata  = rv[RD_LAT-1] ? memval(ra[RD_LAT-1]) : '0;

  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.mem_ready = toggle ? ~bus.mem_ready : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmd_t e;
    logic [1:0] ack_act, ack_exp;
    cyc++;
    ack_act = {bus.host_ack, bus.disp_ack};
    if (bus.mem_req && bus.mem_ready) begin
      n_accept++;
      n_cmp++;
      if (exp_cmd.size() == 0) begin
        n_err++;
        $display("FAIL cmd_unexpected: got we=%0b addr=0x%0h, expected no command", bus.mem_we, bus.mem_addr);
      end else begin
        e = exp_cmd.pop_front();
        ack_exp = {e.ack == 2, e.ack == 1};
        if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || ack_act !== ack_exp ||
            (e.we && bus.mem_wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL cmd: got we=%0b addr=0x%0h wdata=0x%0h acks=%b expected we=%0b addr=0x%0h wdata=0x%0h acks=%b",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, ack_act, e.we, e.addr, e.wdata, ack_exp);
        end
        if (!e.we) begin
          if (e.owner == 1) acc_dcyc.push_back(cyc);
          else acc_hcyc.push_back(cyc);
        end
      end
    end else if (ack_act != 2'b00) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_without_accept: got acks=%b expected 00", ack_act);
    end
    if (prev_stall && bus.mem_req) chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
    prev_stall = bus.mem_req && !bus.mem_ready;
    prev_addr  = bus.mem_addr;
    if (bus.disp_rvalid) begin
      if (exp_drd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL disp_rvalid_unexpected: got data 0x%0h expected none", bus.disp_rdata);
      end else chk("disp_rdata", 32'(bus.disp_rdata), 32'(exp_drd.pop_front()));
      if (acc_dcyc.size() != 0) chk("disp_rd_latency", 32'(cyc - acc_dcyc.pop_front()), RD_LAT);
    end
    if (bus.host_rvalid) begin
      if (exp_hrd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL host_rvalid_unexpected: got data 0x%0h expected none", bus.host_rdata);
      end else chk("host_rdata", 32'(bus.host_rdata), 32'(exp_hrd.pop_front()));
      if (acc_hcyc.size() != 0) chk("host_rd_latency", 32'(cyc - acc_hcyc.pop_front()), RD_LAT);
    end
  end

  task automatic push_burst(input logic [AW-1:0] base, input int unsigned ncmd,
                            input int unsigned nrd, input bit with_ack);
    cmd_t e;
    for (int unsigned i = 0; i < ncmd; i++) begin
      e.we = 1'b0; e.addr = base + AW'(i); e.wdata = '0; e.owner = 1;
      e.ack = (with_ack && i == BURST - 1) ? 1 : 0;
      exp_cmd.push_back(e);
    end
    for (int unsigned i = 0; i < nrd; i++) exp_drd.push_back(memval(base + AW'(i)));
  endtask

  task automatic push_host(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.ack = 2; e.owner = 2;
    exp_cmd.push_back(e);
    if (!we) exp_hrd.push_back(memval(addr));
  endtask

  task automatic wait_ack(input int unsigned which, input int unsigned limit, output int unsigned took);
    bit found = 1'b0;
    took = 0;
    while (!found && took < limit) begin
      @(posedge clk);
      #2;
      took++;
      found = (which == 1) ? bus.disp_ack : bus.host_ack;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no %s ack within %0d cycles, expected one", which == 1 ? "disp" : "host", limit);
    end
  endtask

  task automatic wait_drain(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (n < limit && (exp_cmd.size() + exp_drd.size() + exp_hrd.size() +
                         acc_dcyc.size() + acc_hcyc.size()) != 0) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_pending_cmds"}, exp_cmd.size(), 0);
    chk({tag, "_pending_disp_reads"}, exp_drd.size() + acc_dcyc.size(), 0);
    chk({tag, "_pending_host_reads"}, exp_hrd.size() + acc_hcyc.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"},     32'(bus.mem_req), 0);
    chk({tag, "_mem_we"},      32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"},   32'(bus.mem_wdata), 0);
    chk({tag, "_disp_ack"},    32'(bus.disp_ack), 0);
    chk({tag, "_host_ack"},    32'(bus.host_ack), 0);
    chk({tag, "_disp_rvalid"}, 32'(bus.disp_rvalid), 0);
    chk({tag, "_host_rvalid"}, 32'(bus.host_rvalid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100us, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned took;
    int          base;
    rst_n = 1'b1;
    bus.disp_req = 1'b0; bus.disp_addr = '0; bus.disp_urgent = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Display only: 16 consecutive beats from 0x100, ack on the 16th
    #1 bus.disp_addr = 19'h00100;
    push_burst(19'h00100, BURST, BURST, 1'b1);
    bus.disp_req = 1'b1;
    #3 chk("req_to_mem_req_same_cycle", 32'(bus.mem_req), 0);
    wait_ack(1, 40, took);
    bus.disp_req = 1'b0;
    chk("burst_cycles", took, BURST);
    wait_drain("disp_only", 20);

    // Backpressure: ready toggles every cycle during the burst
    base = n_accept;
    @(posedge clk);
    #2 toggle = 1'b1;
    bus.disp_addr = 19'h00200;
    push_burst(19'h00200, BURST, BURST, 1'b1);
    bus.disp_req = 1'b1;
    wait_ack(1, 80, took);
    bus.disp_req = 1'b0;
    toggle = 1'b0;
    wait_drain("backpressure", 20);
    chk("bp_accepted_beats", 32'(n_accept - base), BURST);

    // Contention: four display bursts, then the host write, then display again
    @(posedge clk);
    #2 bus.disp_addr = 19'h00300;
    bus.host_we = 1'b1; bus.host_addr = 19'h00055; bus.host_wdata = 24'hABCDEF;
    for (int k = 0; k < MAX_DISP; k++) push_burst(19'h00300, BURST, BURST, 1'b1);
    push_host(1'b1, 19'h00055, 24'hABCDEF);
    push_burst(19'h00300, BURST, BURST, 1'b1);
    bus.disp_req = 1'b1; bus.host_req = 1'b1;
    wait_ack(2, 200, took);
    bus.host_req = 1'b0;
    wait_ack(1, 40, took);
    bus.disp_req = 1'b0;
    wait_drain("contention", 20);
    chk("starve_cleared", 32'(dut.starve), 0);

    // Urgent override: six bursts while urgent, host on the first idle after it drops
    @(posedge clk);
    #2 bus.disp_addr = 19'h00380; bus.disp_urgent = 1'b1;
    bus.host_we = 1'b0; bus.host_addr = 19'h00077; bus.host_wdata = '0;
    for (int k = 0; k < 6; k++) push_burst(19'h00380, BURST, BURST, 1'b1);
    push_host(1'b0, 19'h00077, '0);
    push_burst(19'h00380, BURST, BURST, 1'b1);
    bus.disp_req = 1'b1; bus.host_req = 1'b1;
    for (int k = 0; k < 6; k++) wait_ack(1, 40, took);
    bus.disp_urgent = 1'b0;
    wait_ack(2, 40, took);
    bus.host_req = 1'b0;
    wait_ack(1, 40, took);
    bus.disp_req = 1'b0;
    wait_drain("urgent", 20);

    // Mixed routing: host read 0x2A, display burst, then a host write
    @(posedge clk);
    #2 bus.host_we = 1'b0; bus.host_addr = 19'h0002A;
    push_host(1'b0, 19'h0002A, '0);
    bus.host_req = 1'b1;
    wait_ack(2, 10, took);
    bus.host_req = 1'b0;
    bus.disp_addr = 19'h00400;
    push_burst(19'h00400, BURST, BURST, 1'b1);
    bus.disp_req = 1'b1;
    wait_ack(1, 40, took);
    bus.disp_req = 1'b0;
    bus.host_we = 1'b1; bus.host_addr = 19'h00033; bus.host_wdata = 24'h123456;
    push_host(1'b1, 19'h00033, 24'h123456);
    bus.host_req = 1'b1;
    wait_ack(2, 10, took);
    bus.host_req = 1'b0;
    wait_drain("mixed", 20);

    // Reset mid-burst: beats 0..6 accepted, only 0..3 return before reset
    @(posedge clk);
    #2 base = n_accept;
    bus.disp_addr = 19'h00500;
    push_burst(19'h00500, 7, 4, 1'b0);
    bus.disp_req = 1'b1;
    for (int i = 0; i < 40 && (n_accept - base) < 7; i++) begin
      @(posedge clk);
      #2;
    end
    chk("beats_before_reset", 32'(n_accept - base), 7);
    rst_n = 1'b0;
    bus.disp_req = 1'b0;
    #1 check_outputs_zero("mid_reset");
    acc_dcyc.delete();
    acc_hcyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain("post_reset", 10);

    bus.disp_addr = 19'h00600;
    push_burst(19'h00600, BURST, BURST, 1'b1);
    @(posedge clk);
    #1 bus.disp_req = 1'b1;
    wait_ack(1, 40, took);
    bus.disp_req = 1'b0;
    chk("restart_burst_cycles", took, BURST);
    wait_drain("restart", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Arbitrates the single frame-buffer memory port between two requesters:
  - the display line-fetch path, which feeds the VGA timing/RGB pipeline and is latency-critical;
  - a host read/write port (CPU/pattern writer).
- Display traffic is issued as fixed-length read bursts; host accesses are single beats.
- An anti-starvation counter guarantees host progress, except while the display FIFO is urgent.
- Read data is routed back to the owning requester through a fixed-latency tag pipeline.

Parameters:
- AW, 19, memory word address width.
- DW, 24, data width (one RGB pixel per word).
- BURST, 16, beats per display burst; power of two, ≥2.
- RD_LAT, 3, fixed mem_req-accept → mem_rvalid latency in cycles; ≥1.
- MAX_DISP, 4, consecutive display bursts allowed while a host request waits.

Ports:
- pixel_clk  in  1  single clock for the block and the memory port.
- pixel_rst_n  in  1  asynchronous, active-low reset.
- disp_req  in  1  display wants one burst starting at disp_addr; level, held until disp_ack.
- disp_addr  in  AW  burst base address; BURST-aligned.
- disp_urgent  in  1  display line FIFO below low-water mark; overrides starvation guard.
- disp_ack  out  1  one-cycle pulse when the last beat of the burst is accepted by memory.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DW  display read data.
- host_req  in  1  host access request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle pulse when the host beat is accepted by memory.
- host_rvalid  out  1  host read data valid (reads only).
- host_rdata  out  DW  host read data.
- mem_req  out  1  memory command valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ready  in  1  memory accepts the command this cycle when mem_req & mem_ready.
- mem_rvalid  in  1  read data valid, exactly RD_LAT cycles after an accepted read.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (async assert, sync release). All outputs are 0; FSM = IDLE; beat counter = 0; starvation counter = 0; tag pipeline cleared.
- FSM states: IDLE, DISP, HOST.
- IDLE arbitration, evaluated every cycle:
  - disp_req & (disp_urgent | !host_req | starve < MAX_DISP) → DISP.
  - else host_req → HOST.
  - else stay in IDLE.
- Command outputs are registered. mem_req rises on the cycle after the grant decision, so a request raised in cycle N reaches the memory in cycle N+1 at the earliest.
- DISP:
  - mem_req=1, mem_we=0, mem_addr = disp_addr + beat.
  - beat increments on each mem_req & mem_ready.
  - If mem_ready=0, hold all command outputs; no beat is lost.
  - On acceptance of beat BURST-1: pulse disp_ack, beat←0, return to IDLE, mem_req=0 the next cycle.
  - A burst in progress is never preempted, including by host_req or by disp_urgent deassertion.
- HOST:
  - mem_req=1 with mem_we/mem_addr/mem_wdata taken from host_* captured at grant.
  - On acceptance: pulse host_ack, go to IDLE.
- Starvation counter:
  - On each completed display burst while host_req=1: increment, saturating at MAX_DISP.
  - Cleared on host_ack.
  - When starve == MAX_DISP and disp_urgent=0, the next IDLE arbitration grants the host.
- Back-to-back: at least one IDLE cycle between grants. Minimum period is BURST+1 cycles per display burst and 2 cycles per host beat.
- Read return routing:
  - An RD_LAT-deep shift register carries an owner tag per accepted beat: 0=none/write, 1=display read, 2=host read.
  - On mem_rvalid, the tag at the tail selects disp_rvalid or host_rvalid. rdata is forwarded combinationally from mem_rdata to both rdata outputs.
  - mem_rvalid with tail tag = none is ignored. A verification assertion flags this case.
- Host writes produce no rvalid.
- Simultaneous disp_req and host_req with starve < MAX_DISP: display wins.
- disp_addr / host_* changes while not granted are ignored. Requesters must hold them stable until the corresponding ack.
- Reset mid-burst: the burst is abandoned with no ack. In-flight read returns after reset are discarded.

Decomposition:
- Package fb_arb_pkg:
  - typedef enum {IDLE, DISP, HOST} arb_state_t;
  - typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} rd_tag_t.
- One sub-module, rd_tag_pipe (parameterised RD_LAT): the owner-tag shift register plus the rvalid demultiplexer.

Test Plan:
- Display only. disp_req=1, disp_addr=0x100, mem_ready=1 → mem_addr 0x100..0x10F on 16 consecutive cycles; disp_ack in the 0x10F cycle; 16 disp_rvalid pulses, each RD_LAT=3 cycles after its command.
- Backpressure. Toggle mem_ready 1,0,1,0 during a burst → each address is held while ready=0; exactly 16 accepted beats; disp_ack coincides with the 16th accept.
- Contention. disp_req and host_req held continuously, disp_urgent=0 → exactly 4 display bursts, then 1 host beat (host_ack), then display resumes; starve returns to 0.
- Urgent override. Same as the contention test but disp_urgent=1 throughout → the host is never granted while urgent; the host is granted on the first IDLE after urgent drops.
- Mixed read routing. Host read at 0x2A, then a display burst → host_rvalid exactly once, 3 cycles after the host accept, with host_rdata = memory[0x2A]; no display data appears on host_rvalid; a host write yields no rvalid.
- Reset mid-burst. Assert pixel_rst_n=0 at beat 7 → all outputs are 0 immediately (asynchronously); after release, a fresh disp_req restarts at beat 0; no stale rvalid is delivered.
